mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 37 +++
 rtl/mem_byte_seq.sv | 76 +++++++
 rtl/mem_ctrl.sv | 148 ++++++++++++++
 tb/tb_mem_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
// Holds the state encoding, IO address window and legal transfer length codes.
package mem_ctrl_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 3;

    // Writes whose address has this bit field equal to IO_SEL_VAL target the IO buffer
    localparam int         IO_SEL_HI  = 17;
    localparam int         IO_SEL_LO  = 16;
    localparam logic [1:0] IO_SEL_VAL = 2'b11;

    localparam logic [CNT_W-1:0] LEN_BYTE = 3'd1;
    localparam logic [CNT_W-1:0] LEN_HALF = 3'd2;
    localparam logic [CNT_W-1:0] LEN_WORD = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_IF_RD = 2'd1,
        ST_LS_RD = 2'd2,
        ST_LS_WR = 2'd3
    } state_t;

    function automatic logic is_io_addr(input logic [ADDR_W-1:0] a);
        return a[IO_SEL_HI:IO_SEL_LO] == IO_SEL_VAL;
    endfunction

    // Illegal length codes fall back to a full word so the sequencer always terminates
    function automatic logic [CNT_W-1:0] norm_len(input logic [CNT_W-1:0] l);
        case (l)
            LEN_BYTE, LEN_HALF, LEN_WORD: return l;
            default:                      return LEN_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// Byte sequencer: walks addr..addr+len-1, drives RAM address/write byte,
// and assembles read bytes little-endian into a 32-bit word.
module mem_byte_seq
    import mem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [CNT_W-1:0]  i_len,
    input  logic [DATA_W-1:0] i_w_data,
    input  logic              i_adv,
    input  logic              i_abort,
    input  logic [7:0]        i_mem_din,
    output logic [ADDR_W-1:0] o_mem_a,
    output logic [7:0]        o_mem_dout,
    output logic              o_last,
    output logic [DATA_W-1:0] o_rdata_next
);

    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_len;
    logic [DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_mem_a;
    logic [7:0]        r_mem_dout;
    logic [DATA_W-1:0] r_buf;

    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [DATA_W-1:0] w_rdata;

    assign w_cnt_nxt = r_cnt + 3'd1;
    assign o_last    = (r_cnt == r_len - 3'd1);

    // RAM data for the current address is merged into its lane the same cycle
    always_comb begin
        w_rdata = r_buf;
        w_rdata[{r_cnt[1:0], 3'b000} +: 8] = i_mem_din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base     <= '0;
            r_len      <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_mem_a    <= '0;
            r_mem_dout <= '0;
            r_buf      <= '0;
        end else if (i_start) begin
            r_base     <= i_addr;
            r_len      <= i_len;
            r_wdata    <= i_w_data;
            r_cnt      <= '0;
            r_mem_a    <= i_addr;
            r_mem_dout <= i_w_data[7:0];
            r_buf      <= '0;
        end else if (i_abort) begin
            r_cnt <= '0;
        end else if (i_adv) begin
            r_buf <= w_rdata;
            if (o_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt      <= w_cnt_nxt;
                r_mem_a    <= r_base + {{(ADDR_W-CNT_W){1'b0}}, w_cnt_nxt};
                r_mem_dout <= r_wdata[{w_cnt_nxt[1:0], 3'b000} +: 8];
            end
        end
    end

    assign o_mem_a      = r_mem_a;
    assign o_mem_dout   = r_mem_dout;
    assign o_rdata_next = w_rdata;

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates load/store and fetch onto a byte-wide RAM port.
// Define MEM_CTRL_IO_STALL_EN to hold IO-window writes while io_buffer_full is high.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rollback,
    input  logic              lsb_en,
    input  logic              lsb_wr,
    input  logic [ADDR_W-1:0] lsb_addr,
    input  logic [CNT_W-1:0]  lsb_len,
    input  logic [DATA_W-1:0] lsb_w_data,
    output logic              lsb_done,
    output logic [DATA_W-1:0] lsb_r_data,
    input  logic              if_en,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_r_data,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    // state     | meaning
    // ST_IDLE   | waiting for a request; no acceptance during a done cycle
    // ST_IF_RD  | 4-byte fetch, aborted by rollback
    // ST_LS_RD  | load of 1/2/4 bytes, always completes
    // ST_LS_WR  | store of 1/2/4 bytes, always completes

    state_t            r_state;
    logic              r_mem_wr;
    logic              r_lsb_done;
    logic              r_if_done;
    logic [DATA_W-1:0] r_lsb_r_data;
    logic [DATA_W-1:0] r_if_r_data;

    logic              w_idle_ok;
    logic              w_accept_ls;
    logic              w_accept_if;
    logic              w_start;
    logic [ADDR_W-1:0] w_start_addr;
    logic [CNT_W-1:0]  w_start_len;
    logic              w_abort;
    logic              w_adv;
    logic              w_last;
    logic              w_io_hold;
    logic [ADDR_W-1:0] w_mem_a;
    logic [DATA_W-1:0] w_rdata_next;

    // The requester still holds en during the done cycle, so IDLE waits it out
    assign w_idle_ok    = rdy && (r_state == ST_IDLE) && !r_lsb_done && !r_if_done;
    assign w_accept_ls  = w_idle_ok && lsb_en;
    assign w_accept_if  = w_idle_ok && !lsb_en && if_en && !rollback;
    assign w_start      = w_accept_ls || w_accept_if;
    assign w_start_addr = w_accept_ls ? lsb_addr : if_addr;
    assign w_start_len  = w_accept_ls ? norm_len(lsb_len) : LEN_WORD;

    assign w_abort = rdy && (r_state == ST_IF_RD) && rollback;
    assign w_adv   = rdy && (r_state != ST_IDLE) && !w_io_hold && !w_abort;

`ifdef MEM_CTRL_IO_STALL_EN
    assign w_io_hold = (r_state == ST_LS_WR) && is_io_addr(w_mem_a) && io_buffer_full;
`else
    logic w_unused_io;
    assign w_io_hold   = 1'b0;
    assign w_unused_io = io_buffer_full;
`endif

    mem_byte_seq u_seq (
        .clk          (clk),
        .rst_n        (rst),
        .i_start      (w_start),
        .i_addr       (w_start_addr),
        .i_len        (w_start_len),
        .i_w_data     (lsb_w_data),
        .i_adv        (w_adv),
        .i_abort      (w_abort),
        .i_mem_din    (mem_din),
        .o_mem_a      (w_mem_a),
        .o_mem_dout   (mem_dout),
        .o_last       (w_last),
        .o_rdata_next (w_rdata_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_mem_wr     <= 1'b0;
            r_lsb_done   <= 1'b0;
            r_if_done    <= 1'b0;
            r_lsb_r_data <= '0;
            r_if_r_data  <= '0;
        end else if (rdy) begin
            r_lsb_done <= 1'b0;
            r_if_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept_ls) begin
                        r_state  <= lsb_wr ? ST_LS_WR : ST_LS_RD;
                        r_mem_wr <= lsb_wr;
                    end else if (w_accept_if) begin
                        r_state <= ST_IF_RD;
                    end
                end
                ST_IF_RD: begin
                    if (rollback) begin
                        r_state <= ST_IDLE;
                    end else if (w_last) begin
                        r_state     <= ST_IDLE;
                        r_if_done   <= 1'b1;
                        r_if_r_data <= w_rdata_next;
                    end
                end
                ST_LS_RD: begin
                    if (w_last) begin
                        r_state      <= ST_IDLE;
                        r_lsb_done   <= 1'b1;
                        r_lsb_r_data <= w_rdata_next;
                    end
                end
                ST_LS_WR: begin
                    if (w_last && !w_io_hold) begin
                        r_state    <= ST_IDLE;
                        r_mem_wr   <= 1'b0;
                        r_lsb_done <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_mem_wr <= 1'b0;
                end
            endcase
        end
    end

    // A frozen or IO-held byte must never reach the RAM as a write
    assign mem_wr     = r_mem_wr && rdy && !w_io_hold;
    assign mem_a      = w_mem_a;
    assign lsb_done   = r_lsb_done;
    assign lsb_r_data = r_lsb_r_data;
    assign if_done    = r_if_done;
    assign if_r_data  = r_if_r_data;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: table of load/store vectors plus directed
// sequences for arbitration, rollback, rdy freeze, IO stall and mid-write reset.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        rollback = 1'b0;
    logic        lsb_en = 1'b0;
    logic        lsb_wr = 1'b0;
    logic [31:0] lsb_addr = '0;
    logic [2:0]  lsb_len = '0;
    logic [31:0] lsb_w_data = '0;
    logic        lsb_done;
    logic [31:0] lsb_r_data;
    logic        if_en = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic [31:0] if_r_data;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;

    logic [7:0]  ram [0:65535];
    bit          ram_ready = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  len;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [9];

    mem_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .rollback       (rollback),
        .lsb_en         (lsb_en),
        .lsb_wr         (lsb_wr),
        .lsb_addr       (lsb_addr),
        .lsb_len        (lsb_len),
        .lsb_w_data     (lsb_w_data),
        .lsb_done       (lsb_done),
        .lsb_r_data     (lsb_r_data),
        .if_en          (if_en),
        .if_addr        (if_addr),
        .if_done        (if_done),
        .if_r_data      (if_r_data),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input logic [31:0] a);
        return (a[7:0] ^ a[15:8]) + 8'h5A;
    endfunction

    function automatic logic [31:0] fetch_exp(input logic [31:0] a);
        return {pat(a + 32'd3), pat(a + 32'd2), pat(a + 32'd1), pat(a)};
    endfunction

    // Asynchronous-read RAM: mem_din follows mem_a within the cycle; writes land on the edge
    assign mem_din = ram[mem_a[15:0]];

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 65536; i++) ram[i] <= pat(32'(i));
            ram[16'h1000] <= 8'h11;
            ram[16'h1001] <= 8'h22;
            ram[16'h1002] <= 8'h33;
            ram[16'h1003] <= 8'h44;
            ram_ready <= 1'b1;
        end else if (mem_wr) begin
            ram[mem_a[15:0]] <= mem_dout;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_lsb(input int idx, input vec_t v);
        logic [7:0]  eb;
        logic [31:0] a;
        tick();
        lsb_en = 1'b1; lsb_wr = v.wr; lsb_addr = v.addr; lsb_len = v.len; lsb_w_data = v.wdata;
        for (int i = 0; i < int'(v.len); i++) begin
            tick(); #1;
            eb = v.wdata[8*i +: 8];
            chk($sformatf("v%0d_mem_a_b%0d", idx, i), mem_a, v.addr + 32'(i));
            chk($sformatf("v%0d_mem_wr_b%0d", idx, i), 32'(mem_wr), 32'(v.wr));
            if (v.wr) chk($sformatf("v%0d_mem_dout_b%0d", idx, i), 32'(mem_dout), 32'(eb));
            chk($sformatf("v%0d_done_early_b%0d", idx, i), 32'(lsb_done), 32'd0);
        end
        tick(); #1;
        chk($sformatf("v%0d_lsb_done", idx), 32'(lsb_done), 32'd1);
        chk($sformatf("v%0d_mem_wr_done", idx), 32'(mem_wr), 32'd0);
        if (!v.wr) chk($sformatf("v%0d_lsb_r_data", idx), lsb_r_data, v.exp);
        tick();
        lsb_en = 1'b0;
        #1;
        chk($sformatf("v%0d_done_pulse", idx), 32'(lsb_done), 32'd0);
        chk($sformatf("v%0d_no_reaccept", idx), 32'(mem_wr), 32'd0);
        if (v.wr) begin
            for (int i = 0; i < int'(v.len); i++) begin
                a  = v.addr + 32'(i);
                eb = v.wdata[8*i +: 8];
                chk($sformatf("v%0d_ram_b%0d", idx, i), 32'(ram[a[15:0]]), 32'(eb));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] exp_if;
        vec_t        v;
        logic        exp_wr   [6];
        logic        exp_done [6];

        vecs[0] = '{1'b0, 32'h0000_1000, 3'd4, 32'h0,         32'h4433_2211};
        vecs[1] = '{1'b1, 32'h0000_2002, 3'd2, 32'hDEAD_BEEF, 32'h0};
        vecs[2] = '{1'b0, 32'h0000_2002, 3'd2, 32'h0,         32'h0000_BEEF};
        vecs[3] = '{1'b0, 32'h0000_0040, 3'd1, 32'h0,         {24'h0, pat(32'h40)}};
        vecs[4] = '{1'b1, 32'hFFFF_FFFF, 3'd2, 32'h0000_A5C3, 32'h0};
        vecs[5] = '{1'b0, 32'hFFFF_FFFF, 3'd2, 32'h0,         32'h0000_A5C3};
        vecs[6] = '{1'b1, 32'h0000_3000, 3'd4, 32'h0102_0304, 32'h0};
        vecs[7] = '{1'b0, 32'h0000_3000, 3'd4, 32'h0,         32'h0102_0304};
        vecs[8] = '{1'b0, 32'h0000_1001, 3'd1, 32'h0,         32'h0000_0022};

        #3;
        chk("rst_mem_wr",     32'(mem_wr),   32'd0);
        chk("rst_mem_a",      mem_a,         32'd0);
        chk("rst_mem_dout",   32'(mem_dout), 32'd0);
        chk("rst_lsb_done",   32'(lsb_done), 32'd0);
        chk("rst_if_done",    32'(if_done),  32'd0);
        chk("rst_lsb_r_data", lsb_r_data,    32'd0);
        chk("rst_if_r_data",  if_r_data,     32'd0);
        #19;
        rst = 1'b1;
        tick();

        for (int k = 0; k < 9; k++) run_lsb(k, vecs[k]);
        chk("ram_2001_untouched", 32'(ram[16'h2001]), 32'(pat(32'h2001)));
        chk("ram_2004_untouched", 32'(ram[16'h2004]), 32'(pat(32'h2004)));

        // Arbitration: load wins, fetch waits through the done cycle
        tick();
        lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h40; lsb_len = 3'd1;
        if_en = 1'b1; if_addr = 32'h80;
        tick(); #1;
        chk("arb_lsb_first", mem_a, 32'h40);
        tick(); #1;
        chk("arb_lsb_done", 32'(lsb_done), 32'd1);
        chk("arb_lsb_r_data", lsb_r_data, {24'h0, pat(32'h40)});
        chk("arb_if_done_low", 32'(if_done), 32'd0);
        tick();
        lsb_en = 1'b0;
        #1;
        chk("arb_idle_mem_wr", 32'(mem_wr), 32'd0);
        tick();
        if_en = 1'b0;
        #1;
        chk("arb_fetch_b0", mem_a, 32'h80);
        for (int k = 1; k < 4; k++) begin
            tick(); #1;
            chk($sformatf("arb_fetch_b%0d", k), mem_a, 32'h80 + 32'(k));
            chk($sformatf("arb_if_early_%0d", k), 32'(if_done), 32'd0);
        end
        tick(); #1;
        exp_if = fetch_exp(32'h80);
        chk("arb_if_done", 32'(if_done), 32'd1);
        chk("arb_if_r_data", if_r_data, exp_if);
        tick(); #1;
        chk("arb_if_pulse", 32'(if_done), 32'd0);
        chk("arb_if_r_hold", if_r_data, exp_if);

        // Rollback on the second fetch byte, then a clean fetch
        tick();
        if_en = 1'b1; if_addr = 32'h100;
        tick();
        if_en = 1'b0;
        #1;
        chk("rb_b0", mem_a, 32'h100);
        tick();
        rollback = 1'b1;
        #1;
        chk("rb_b1", mem_a, 32'h101);
        tick();
        rollback = 1'b0; if_en = 1'b1; if_addr = 32'h200;
        #1;
        chk("rb_no_if_done", 32'(if_done), 32'd0);
        chk("rb_mem_wr", 32'(mem_wr), 32'd0);
        tick();
        if_en = 1'b0;
        #1;
        chk("rb_fetch2_b0", mem_a, 32'h200);
        for (int k = 1; k < 4; k++) begin
            tick(); #1;
            chk($sformatf("rb_if_early_%0d", k), 32'(if_done), 32'd0);
        end
        tick(); #1;
        chk("rb_fetch2_done", 32'(if_done), 32'd1);
        chk("rb_fetch2_data", if_r_data, fetch_exp(32'h200));

        // rdy low freezes a write in progress and suppresses mem_wr
        tick();
        lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h500; lsb_len = 3'd2; lsb_w_data = 32'h0000_7788;
        tick();
        lsb_en = 1'b0;
        #1;
        chk("rdy_b0_wr", 32'(mem_wr), 32'd1);
        chk("rdy_b0_dout", 32'(mem_dout), 32'h88);
        tick();
        rdy = 1'b0;
        #1;
        chk("rdy_frz_wr0", 32'(mem_wr), 32'd0);
        chk("rdy_frz_a0", mem_a, 32'h501);
        tick(); #1;
        chk("rdy_frz_wr1", 32'(mem_wr), 32'd0);
        chk("rdy_frz_a1", mem_a, 32'h501);
        chk("rdy_frz_done", 32'(lsb_done), 32'd0);
        tick();
        rdy = 1'b1;
        #1;
        chk("rdy_b1_wr", 32'(mem_wr), 32'd1);
        chk("rdy_b1_dout", 32'(mem_dout), 32'h77);
        tick(); #1;
        chk("rdy_done", 32'(lsb_done), 32'd1);
        chk("rdy_ram_501", 32'(ram[16'h0501]), 32'h77);

        // IO-window byte write against a full IO buffer
`ifdef MEM_CTRL_IO_STALL_EN
        exp_wr   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
        exp_wr   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_done = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        tick();
        lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h0003_0000; lsb_len = 3'd1; lsb_w_data = 32'h0000_005A;
        io_buffer_full = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            lsb_en = 1'b0;
            if (k == 3) io_buffer_full = 1'b0;
            #1;
            chk($sformatf("io_mem_wr_c%0d", k), 32'(mem_wr), 32'(exp_wr[k]));
            chk($sformatf("io_done_c%0d", k), 32'(lsb_done), 32'(exp_done[k]));
        end
        chk("io_ram", 32'(ram[16'h0000]), 32'h5A);

        // Reset in the middle of a 4-byte write, after the first byte
        tick();
        lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h600; lsb_len = 3'd4; lsb_w_data = 32'h1122_3344;
        tick();
        lsb_en = 1'b0;
        #1;
        chk("mr_b0_wr", 32'(mem_wr), 32'd1);
        tick();
        rst = 1'b0;
        #1;
        chk("mr_mem_wr",     32'(mem_wr),   32'd0);
        chk("mr_mem_a",      mem_a,         32'd0);
        chk("mr_mem_dout",   32'(mem_dout), 32'd0);
        chk("mr_lsb_done",   32'(lsb_done), 32'd0);
        chk("mr_if_done",    32'(if_done),  32'd0);
        chk("mr_lsb_r_data", lsb_r_data,    32'd0);
        chk("mr_if_r_data",  if_r_data,     32'd0);
        tick();
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick(); #1;
            chk($sformatf("mr_no_done_%0d", k), 32'(lsb_done), 32'd0);
            chk($sformatf("mr_no_wr_%0d", k), 32'(mem_wr), 32'd0);
        end
        chk("mr_ram_600", 32'(ram[16'h0600]), 32'h44);
        chk("mr_ram_601", 32'(ram[16'h0601]), 32'(pat(32'h601)));
        v = '{1'b0, 32'h0000_0600, 3'd1, 32'h0, 32'h0000_0044};
        run_lsb(9, v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
